// File: rtl/core_bus_arbiter_pkg.sv
// Shared core bus types: pointer/word widths, bus owner and arbiter state
// encodings, and the request bundle carried from each port onto the bus.
package core_bus_arbiter_pkg;

  typedef logic [29:0] ptr;
  typedef logic [31:0] word;

  typedef enum logic [1:0] {
    BUS_NONE,
    BUS_INSN,
    BUS_DATA
  } bus_owner;

  typedef enum logic [1:0] {
    BUS_IDLE,
    BUS_ISSUE,
    BUS_WAIT
  } bus_arb_state;

  typedef struct packed {
    ptr         addr;
    logic       write;
    word        data_wr;
    logic [3:0] be;
  } bus_req;

  localparam logic [3:0] BE_ALL = 4'b1111;

endpackage

// File: rtl/core_bus_req_latch.sv
// Per-port request latch. A start pulse either goes straight to the arbiter
// (when granted in the same cycle) or is held as pending until granted.
// Starts arriving while the port is pending or in flight are dropped.
module core_bus_req_latch
  import core_bus_arbiter_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   start,
  input  logic   busy,
  input  logic   grant,
  input  bus_req req_in,
  output logic   valid,
  output bus_req req
);

  logic   pending;
  bus_req held;
  logic   accept;

  // A fresh start is only honoured when nothing is outstanding for this port,
  // and it is visible to the arbiter in the same cycle to save a cycle.
  assign accept = start && !pending && !busy;
  assign valid  = pending || accept;
  assign req    = pending ? held : req_in;

  // Capture the request fields and track the pending flag until granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= 1'b0;
      held    <= '0;
    end else begin
      if (grant) begin
        pending <= 1'b0;
      end else if (accept) begin
        pending <= 1'b1;
      end
      if (accept) begin
        held <= req_in;
      end
    end
  end

  // Flag a requester that starts again before its previous request finished.
  always_ff @(posedge clk) begin
    if (!rst && start) begin
      assert (!pending && !busy);
    end
  end

endmodule

// File: rtl/core_bus_arbiter.sv
// Core memory bus arbiter between the fetch port and the load/store port.
// One bus transaction is outstanding at a time; read data and a one-cycle
// ready pulse are returned to the owning port.
// Optional macro CORE_BUS_ARB_RR_EN selects round-robin arbitration on
// conflict; without it the data port always wins.
module core_bus_arbiter
  import core_bus_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       insn_start,
  input  ptr         insn_addr,
  output logic       insn_ready,
  output word        insn_data,
  input  logic       data_start,
  input  ptr         data_addr,
  input  logic       data_write,
  input  word        data_data_wr,
  input  logic [3:0] data_data_be,
  output logic       data_ready,
  output word        data_data_rd,
  output logic       mem_start,
  output ptr         mem_addr,
  output logic       mem_write,
  output word        mem_data_wr,
  output logic [3:0] mem_data_be,
  input  logic       mem_ready,
  input  word        mem_data_rd
);

  bus_arb_state state;
  bus_owner     owner;
  bus_owner     winner;
  bus_req       insn_in;
  bus_req       data_in;
  bus_req       insn_req;
  bus_req       data_req;
  bus_req       win_req;
  logic         insn_valid;
  logic         data_valid;
  logic         grant_insn;
  logic         grant_data;

  assign insn_in = '{addr: insn_addr, write: 1'b0, data_wr: '0, be: BE_ALL};
  assign data_in = '{addr: data_addr, write: data_write, data_wr: data_data_wr,
                     be: data_data_be};

  core_bus_req_latch u_insn_latch (
    .clk    (clk),
    .rst    (rst),
    .start  (insn_start),
    .busy   (owner == BUS_INSN),
    .grant  (grant_insn),
    .req_in (insn_in),
    .valid  (insn_valid),
    .req    (insn_req)
  );

  core_bus_req_latch u_data_latch (
    .clk    (clk),
    .rst    (rst),
    .start  (data_start),
    .busy   (owner == BUS_DATA),
    .grant  (grant_data),
    .req_in (data_in),
    .valid  (data_valid),
    .req    (data_req)
  );

`ifdef CORE_BUS_ARB_RR_EN
  bus_owner last_owner;

  // Remember who was granted most recently so the other port wins a conflict.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_owner <= BUS_INSN;
    end else if (state == BUS_IDLE && winner != BUS_NONE) begin
      last_owner <= winner;
    end
  end
`endif

  // Pick the next owner among the valid requesters.
  always_comb begin
    winner = BUS_NONE;
    if (insn_valid && data_valid) begin
`ifdef CORE_BUS_ARB_RR_EN
      winner = (last_owner == BUS_DATA) ? BUS_INSN : BUS_DATA;
`else
      winner = BUS_DATA;
`endif
    end else if (data_valid) begin
      winner = BUS_DATA;
    end else if (insn_valid) begin
      winner = BUS_INSN;
    end
  end

  assign grant_insn = (state == BUS_IDLE) && (winner == BUS_INSN);
  assign grant_data = (state == BUS_IDLE) && (winner == BUS_DATA);
  assign win_req    = (winner == BUS_DATA) ? data_req : insn_req;

  // Bus sequencing: grant, pulse mem_start once, then wait for completion and
  // steer the read data and ready pulse back to the owner.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= BUS_IDLE;
      owner        <= BUS_NONE;
      mem_start    <= 1'b0;
      mem_addr     <= '0;
      mem_write    <= 1'b0;
      mem_data_wr  <= '0;
      mem_data_be  <= '0;
      insn_ready   <= 1'b0;
      insn_data    <= '0;
      data_ready   <= 1'b0;
      data_data_rd <= '0;
    end else begin
      mem_start  <= 1'b0;
      insn_ready <= 1'b0;
      data_ready <= 1'b0;
      case (state)
        BUS_IDLE: begin
          if (winner != BUS_NONE) begin
            state       <= BUS_ISSUE;
            owner       <= winner;
            mem_start   <= 1'b1;
            mem_addr    <= win_req.addr;
            mem_write   <= win_req.write;
            mem_data_wr <= win_req.data_wr;
            mem_data_be <= win_req.be;
          end
        end
        BUS_ISSUE: begin
          state <= BUS_WAIT;
        end
        BUS_WAIT: begin
          if (mem_ready) begin
            state <= BUS_IDLE;
            owner <= BUS_NONE;
            if (owner == BUS_INSN) begin
              insn_data  <= mem_data_rd;
              insn_ready <= 1'b1;
            end else if (owner == BUS_DATA) begin
              data_data_rd <= mem_data_rd;
              data_ready   <= 1'b1;
            end
          end
        end
        default: begin
          state <= BUS_IDLE;
          owner <= BUS_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Directed bench for core_bus_arbiter. Inputs change on the falling edge and
// outputs are sampled on the falling edge, half a cycle after the active edge.
// Expected arbitration order follows CORE_BUS_ARB_RR_EN when it is defined.
module tb_core_bus_arbiter;
  import core_bus_arbiter_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       insn_start;
  ptr         insn_addr;
  logic       insn_ready;
  word        insn_data;
  logic       data_start;
  ptr         data_addr;
  logic       data_write;
  word        data_data_wr;
  logic [3:0] data_data_be;
  logic       data_ready;
  word        data_data_rd;
  logic       mem_start;
  ptr         mem_addr;
  logic       mem_write;
  word        mem_data_wr;
  logic [3:0] mem_data_be;
  logic       mem_ready;
  word        mem_data_rd;

  int vectorCount = 0;
  int missCount   = 0;

`ifdef CORE_BUS_ARB_RR_EN
  localparam logic RR_MODE = 1'b1;
`else
  localparam logic RR_MODE = 1'b0;
`endif

  core_bus_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .insn_start   (insn_start),
    .insn_addr    (insn_addr),
    .insn_ready   (insn_ready),
    .insn_data    (insn_data),
    .data_start   (data_start),
    .data_addr    (data_addr),
    .data_write   (data_write),
    .data_data_wr (data_data_wr),
    .data_data_be (data_data_be),
    .data_ready   (data_ready),
    .data_data_rd (data_data_rd),
    .mem_start    (mem_start),
    .mem_addr     (mem_addr),
    .mem_write    (mem_write),
    .mem_data_wr  (mem_data_wr),
    .mem_data_be  (mem_data_be),
    .mem_ready    (mem_ready),
    .mem_data_rd  (mem_data_rd)
  );

  // Free-running core clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic is, input ptr ia, input logic ds,
                               input ptr da, input logic dw, input word dwr,
                               input logic [3:0] dbe, input logic mr,
                               input word mrd);
    insn_start   = is;
    insn_addr    = ia;
    data_start   = ds;
    data_addr    = da;
    data_write   = dw;
    data_data_wr = dwr;
    data_data_be = dbe;
    mem_ready    = mr;
    mem_data_rd  = mrd;
    @(negedge clk);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, 4'h0, 1'b0, '0);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " mem_start"},   32'(mem_start),   32'h0);
    checkOutput({tag, " insn_ready"},  32'(insn_ready),  32'h0);
    checkOutput({tag, " data_ready"},  32'(data_ready),  32'h0);
    checkOutput({tag, " mem_write"},   32'(mem_write),   32'h0);
    checkOutput({tag, " mem_data_be"}, 32'(mem_data_be), 32'h0);
    checkOutput({tag, " mem_addr"},    32'(mem_addr),    32'h0);
    checkOutput({tag, " mem_data_wr"}, mem_data_wr,      32'h0);
    checkOutput({tag, " insn_data"},   insn_data,        32'h0);
    checkOutput({tag, " data_rd"},     data_data_rd,     32'h0);
  endtask

  initial begin
    rst = 1'b1;
    insn_start = 1'b0; insn_addr = '0; data_start = 1'b0; data_addr = '0;
    data_write = 1'b0; data_data_wr = '0; data_data_be = '0;
    mem_ready = 1'b0; mem_data_rd = '0;
    repeat (2) @(negedge clk);
    checkResetState("reset");
    rst = 1'b0;

    // Single store, mem_ready on the first WAIT cycle.
    applyStimulus(1'b0, '0, 1'b1, 30'h40, 1'b1, 32'h12345678, 4'h3, 1'b0, '0);
    checkOutput("st mem_start", 32'(mem_start),   32'h1);
    checkOutput("st mem_addr",  32'(mem_addr),    32'h40);
    checkOutput("st mem_write", 32'(mem_write),   32'h1);
    checkOutput("st mem_wr",    mem_data_wr,      32'h12345678);
    checkOutput("st mem_be",    32'(mem_data_be), 32'h3);
    idleCycle();
    checkOutput("st start low", 32'(mem_start),   32'h0);
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, 4'h0, 1'b1, 32'hCAFEF00D);
    checkOutput("st data_ready", 32'(data_ready), 32'h1);
    checkOutput("st insn_ready", 32'(insn_ready), 32'h0);
    checkOutput("st data_rd",    data_data_rd,    32'hCAFEF00D);
    idleCycle();
    checkOutput("st ready pulse", 32'(data_ready), 32'h0);
    checkOutput("st addr hold",   32'(mem_addr),   32'h40);

    // Single fetch, mem_ready three cycles after mem_start.
    applyStimulus(1'b1, 30'h100, 1'b0, '0, 1'b0, '0, 4'h0, 1'b0, '0);
    checkOutput("if mem_start", 32'(mem_start),   32'h1);
    checkOutput("if mem_addr",  32'(mem_addr),    32'h100);
    checkOutput("if mem_write", 32'(mem_write),   32'h0);
    checkOutput("if mem_be",    32'(mem_data_be), 32'hF);
    repeat (3) begin
      idleCycle();
      checkOutput("if early ready", 32'(insn_ready), 32'h0);
      checkOutput("if restart",     32'(mem_start),  32'h0);
    end
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, 4'h0, 1'b1, 32'hDEADBEEF);
    checkOutput("if insn_ready", 32'(insn_ready), 32'h1);
    checkOutput("if insn_data",  insn_data,       32'hDEADBEEF);
    checkOutput("if data_ready", 32'(data_ready), 32'h0);
    checkOutput("if data hold",  data_data_rd,    32'hCAFEF00D);
    idleCycle();
    checkOutput("if ready pulse", 32'(insn_ready), 32'h0);

    // Conflict after a fetch grant: data first in both modes.
    applyStimulus(1'b1, 30'h200, 1'b1, 30'h300, 1'b0, '0, 4'hF, 1'b0, '0);
    checkOutput("c1 start", 32'(mem_start), 32'h1);
    checkOutput("c1 addr0", 32'(mem_addr),  32'h300);
    idleCycle();
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, 4'h0, 1'b1, 32'h11111111);
    checkOutput("c1 data_ready", 32'(data_ready), 32'h1);
    checkOutput("c1 no overlap", 32'(mem_start),  32'h0);
    idleCycle();
    checkOutput("c1 start1",     32'(mem_start),  32'h1);
    checkOutput("c1 addr1",      32'(mem_addr),   32'h200);
    checkOutput("c1 be1",        32'(mem_data_be), 32'hF);
    checkOutput("c1 data pulse", 32'(data_ready), 32'h0);
    idleCycle();
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, 4'h0, 1'b1, 32'h22222222);
    checkOutput("c1 insn_ready", 32'(insn_ready), 32'h1);
    checkOutput("c1 insn_data",  insn_data,       32'h22222222);
    checkOutput("c1 data hold",  data_data_rd,    32'h11111111);
    idleCycle();

    // Data start in the same cycle as the fetch's mem_ready.
    applyStimulus(1'b1, 30'h10, 1'b0, '0, 1'b0, '0, 4'h0, 1'b0, '0);
    idleCycle();
    applyStimulus(1'b0, '0, 1'b1, 30'h20, 1'b0, '0, 4'hF, 1'b1, 32'h33333333);
    checkOutput("sc insn_ready", 32'(insn_ready), 32'h1);
    checkOutput("sc gap",        32'(mem_start),  32'h0);
    idleCycle();
    checkOutput("sc start",      32'(mem_start),  32'h1);
    checkOutput("sc addr",       32'(mem_addr),   32'h20);
    checkOutput("sc insn pulse", 32'(insn_ready), 32'h0);
    idleCycle();
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, 4'h0, 1'b1, 32'h44444444);
    checkOutput("sc data_ready", 32'(data_ready), 32'h1);
    checkOutput("sc insn quiet", 32'(insn_ready), 32'h0);
    checkOutput("sc data_rd",    data_data_rd,    32'h44444444);
    idleCycle();
    checkOutput("sc data pulse", 32'(data_ready), 32'h0);

    // Stray mem_ready while idle.
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, 4'h0, 1'b1, 32'hBAD0BAD0);
    checkOutput("sy insn_ready", 32'(insn_ready), 32'h0);
    checkOutput("sy data_ready", 32'(data_ready), 32'h0);
    checkOutput("sy mem_start",  32'(mem_start),  32'h0);
    checkOutput("sy data hold",  data_data_rd,    32'h44444444);
    checkOutput("sy insn hold",  insn_data,       32'h33333333);
    idleCycle();
    checkOutput("sy still idle", 32'(mem_start),  32'h0);

    // Conflict after a data grant: fetch first only with round-robin.
    applyStimulus(1'b1, 30'h60, 1'b1, 30'h70, 1'b0, '0, 4'hF, 1'b0, '0);
    checkOutput("c2 start",  32'(mem_start), 32'h1);
    checkOutput("c2 addr0",  32'(mem_addr),  RR_MODE ? 32'h60 : 32'h70);
    idleCycle();
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, 4'h0, 1'b1, 32'h55555555);
    checkOutput("c2 insn_ready0", 32'(insn_ready), RR_MODE ? 32'h1 : 32'h0);
    checkOutput("c2 data_ready0", 32'(data_ready), RR_MODE ? 32'h0 : 32'h1);
    idleCycle();
    checkOutput("c2 addr1", 32'(mem_addr), RR_MODE ? 32'h70 : 32'h60);
    idleCycle();
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, 4'h0, 1'b1, 32'h66666666);
    checkOutput("c2 insn_ready1", 32'(insn_ready), RR_MODE ? 32'h0 : 32'h1);
    checkOutput("c2 data_ready1", 32'(data_ready), RR_MODE ? 32'h1 : 32'h0);
    checkOutput("c2 insn_data", insn_data,    RR_MODE ? 32'h55555555 : 32'h66666666);
    checkOutput("c2 data_rd",   data_data_rd, RR_MODE ? 32'h66666666 : 32'h55555555);
    idleCycle();

    // Reset during WAIT, then a stray mem_ready.
    applyStimulus(1'b1, 30'h80, 1'b0, '0, 1'b0, '0, 4'h0, 1'b0, '0);
    idleCycle();
    rst = 1'b1;
    idleCycle();
    rst = 1'b0;
    checkResetState("rw");
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, 4'h0, 1'b1, 32'h77777777);
    checkOutput("rw insn_ready", 32'(insn_ready), 32'h0);
    checkOutput("rw data_ready", 32'(data_ready), 32'h0);
    checkOutput("rw mem_start",  32'(mem_start),  32'h0);
    repeat (2) begin
      idleCycle();
      checkOutput("rw no reissue", 32'(mem_start), 32'h0);
      checkOutput("rw insn_data",  insn_data,      32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
